// File: rtl/snn_pkg.sv
// snn_pkg
// Shared constants and the sequencer state encoding for the SNN inference
// controller and its argmax scan helper.
package snn_pkg;

    localparam int NUM_CLASSES  = 10;  // readout accumulators scanned
    localparam int WIDTH_P      = 8;   // accumulator / sample width
    localparam int IDX_W        = 4;   // class index width
    localparam int CLEAR_CYCLES = 2;   // cycles layer_clr_o is held
    localparam int PIPE_DEPTH   = 3;   // synapse + two LIF stages
    localparam int WINDOW_W     = 8;   // timestep count width
    localparam int CNT_W        = 8;   // phase counter, covers 255 timesteps

    // A zero window still presents the sample for one timestep.
    localparam logic [WINDOW_W-1:0] WINDOW_MIN = 8'd1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_SCAN   = 3'd4,
        ST_RESULT = 3'd5
    } state_t;

endpackage

// File: rtl/snn_argmax_scan.sv
// snn_argmax_scan
// Serial argmax: one candidate per enabled cycle, strict-greater compare so
// ties keep the lower index.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   clr_i               reset best index/score to 0/0
//   en_i                compare idx_i/data_i against the running best
//   idx_i, data_i       candidate index and value
//   best_idx_o/score_o  registered running best
//   nxt_idx_o/score_o   best including the current candidate (combinational)
module snn_argmax_scan
    import snn_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [WIDTH_P-1:0] data_i,
    output logic [IDX_W-1:0]   best_idx_o,
    output logic [WIDTH_P-1:0] best_score_o,
    output logic [IDX_W-1:0]   nxt_idx_o,
    output logic [WIDTH_P-1:0] nxt_score_o
);

    logic take;

    always_comb begin
        take        = en_i && (data_i > best_score_o);
        nxt_idx_o   = take ? idx_i  : best_idx_o;
        nxt_score_o = take ? data_i : best_score_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            best_idx_o   <= '0;
            best_score_o <= '0;
        end else if (en_i) begin
            best_idx_o   <= nxt_idx_o;
            best_score_o <= nxt_score_o;
        end
    end

endmodule

// File: rtl/snn_inference_ctrl.sv
// snn_inference_ctrl
// Sequences one inference: clear network state, present the latched sample
// for a programmable number of timesteps, drain the spike pipeline, scan the
// readout accumulators for the argmax and return it over valid/ready.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, abort_i        request / cancel an inference
//   sample_i, window_i      sample and timestep count, latched on start
//   busy_o                  CLEAR/RUN/DRAIN/SCAN in progress
//   layer_clr_o, step_en_o  network clear and timestep enable
//   data_o                  sample to synapses (0 outside RUN)
//   acc_sel_o, acc_data_i   accumulator select and its value
//   result_valid_o/ready_i  result handshake
//   class_o, score_o        argmax index and value
//
// state  | meaning
// IDLE   | waiting for start_i
// CLEAR  | layer_clr_o held for CLEAR_CYCLES
// RUN    | timesteps with the latched sample applied
// DRAIN  | timesteps with zero input, flushing in-flight spikes
// SCAN   | one accumulator compared per cycle
// RESULT | result_valid_o high until result_ready_i
module snn_inference_ctrl
    import snn_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [WIDTH_P-1:0]  sample_i,
    input  logic [WINDOW_W-1:0] window_i,
    output logic                busy_o,
    output logic                layer_clr_o,
    output logic                step_en_o,
    output logic [WIDTH_P-1:0]  data_o,
    output logic [IDX_W-1:0]    acc_sel_o,
    input  logic [WIDTH_P-1:0]  acc_data_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [IDX_W-1:0]    class_o,
    output logic [WIDTH_P-1:0]  score_o
);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH_P-1:0]  sample_q;
    logic [WINDOW_W-1:0] window_q;

    logic                scan_clr;
    logic                scan_en;
    logic [IDX_W-1:0]    best_idx;
    logic [WIDTH_P-1:0]  best_score;
    logic [IDX_W-1:0]    nxt_idx;
    logic [WIDTH_P-1:0]  nxt_score;

    // The running best is scratch; class_o/score_o only take it when the
    // scan completes, so an abort leaves the previous result visible.
    assign scan_clr = (state == ST_DRAIN) && (cnt == '0);
    assign scan_en  = (state == ST_SCAN);

    snn_argmax_scan u_scan (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (scan_clr),
        .en_i         (scan_en),
        .idx_i        (acc_sel_o),
        .data_i       (acc_data_i),
        .best_idx_o   (best_idx),
        .best_score_o (best_score),
        .nxt_idx_o    (nxt_idx),
        .nxt_score_o  (nxt_score)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            sample_q       <= '0;
            window_q       <= '0;
            busy_o         <= 1'b0;
            layer_clr_o    <= 1'b0;
            step_en_o      <= 1'b0;
            data_o         <= '0;
            acc_sel_o      <= '0;
            result_valid_o <= 1'b0;
            class_o        <= '0;
            score_o        <= '0;
        end else if (abort_i && (state inside {ST_CLEAR, ST_RUN, ST_DRAIN, ST_SCAN})) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            busy_o      <= 1'b0;
            layer_clr_o <= 1'b0;
            step_en_o   <= 1'b0;
            data_o      <= '0;
            acc_sel_o   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        sample_q    <= sample_i;
                        window_q    <= (window_i == '0) ? WINDOW_MIN : window_i;
                        state       <= ST_CLEAR;
                        cnt         <= CNT_W'(CLEAR_CYCLES - 1);
                        busy_o      <= 1'b1;
                        layer_clr_o <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt == '0) begin
                        state       <= ST_RUN;
                        cnt         <= window_q - 1'b1;
                        layer_clr_o <= 1'b0;
                        step_en_o   <= 1'b1;
                        data_o      <= sample_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cnt == '0) begin
                        state  <= ST_DRAIN;
                        cnt    <= CNT_W'(PIPE_DEPTH - 1);
                        data_o <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == '0) begin
                        state     <= ST_SCAN;
                        cnt       <= CNT_W'(NUM_CLASSES - 1);
                        step_en_o <= 1'b0;
                        acc_sel_o <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (cnt == '0) begin
                        // Last candidate is folded in through the next-best path.
                        state          <= ST_RESULT;
                        busy_o         <= 1'b0;
                        acc_sel_o      <= '0;
                        result_valid_o <= 1'b1;
                        class_o        <= nxt_idx;
                        score_o        <= nxt_score;
                    end else begin
                        cnt       <= cnt - 1'b1;
                        acc_sel_o <= acc_sel_o + 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (result_ready_i) begin
                        state          <= ST_IDLE;
                        result_valid_o <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered best is only observed through nxt_*; keep it referenced.
    logic unused_best;
    assign unused_best = ^{best_idx, best_score};

endmodule
